time_counter_prog: RTL
======================

Name: time_counter_prog

Overview:
- Parametrised successor to the clock/alarm time counter: free-running h:m:s timekeeper with a clock-enable prescaler, run-time 12/24-hour display mode, single-cycle field adjust inputs, validated parallel time load and rollover strobes.
- Sits between the system clock/prescaler and the display and alarm-compare logic.
- Strobes let the alarm block compare once per minute instead of every cycle.

Parameters:
- CLK_DIV, 1, clk cycles per second tick (>=1); prescaler counter width is max(1, $clog2(CLK_DIV)).
- INIT_HOURS, 0, hour (0..23) loaded on reset.
- INIT_MINS, 0, minute (0..59) loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  1 = prescaler counts and time advances; 0 = freeze prescaler and time.
- mode_24h  in  1  display mode: 1 = 24-hour, 0 = 12-hour.
- HOURS  in  1  adjust pulse: hour +1 mod 24, no carry.
- MINS  in  1  adjust pulse: minute +1 mod 60, no carry into hour.
- SECS  in  1  adjust pulse: clear seconds and prescaler.
- load_valid  in  1  load request, sampled every cycle.
- load_hours  in  5  hour to load, 0..23.
- load_mins  in  6  minute to load, 0..59.
- load_secs  in  6  second to load, 0..59.
- HOURS_OUT  out  5  displayed hour: 24h mode 0..23; 12h mode 12,1..11.
- MINUTES_OUT  out  6  0..59.
- SECS_OUT  out  6  0..59.
- AM_PM_OUT  out  1  0 = internal hour 0..11, 1 = 12..23, in both modes.
- min_pulse  out  1  one-cycle strobe: seconds wrapped 59->0 via tick.
- hour_pulse  out  1  one-cycle strobe: minutes wrapped 59->0 via tick carry.
- day_pulse  out  1  one-cycle strobe: hours wrapped 23->0 via tick carry.
- load_err  out  1  one-cycle strobe: load rejected.

Behaviour:
- State: hr 0..23, mn 0..59, sc 0..59, prescaler pc 0..CLK_DIV-1. All flops.
- Reset (async, any time, including mid-load): hr=INIT_HOURS, mn=INIT_MINS, sc=0, pc=0. All strobes 0.
- Display decode is combinational from state; no extra latency.
  - HOURS_OUT = hr in 24h mode.
  - In 12h mode: hr 0 -> 12, hr 13..23 -> hr-12, otherwise hr.
  - mode_24h changes affect display only, never state.
- Tick:
  - When run=1, pc increments.
  - At pc==CLK_DIV-1, pc wraps to 0 and tick=1 for that cycle.
  - CLK_DIV=1 gives tick every run cycle.
  - run=0 holds pc, with no tick.
- Per-edge priority, highest first:
  - 1. load_valid=1:
    - If load_hours<=23, load_mins<=59 and load_secs<=59: hr/mn/sc take the load values and pc=0.
    - Otherwise state is unchanged (pc keeps counting) and load_err=1 next cycle.
    - Any adjust or tick in that cycle is dropped.
  - 2. Any of HOURS/MINS/SECS high: apply every asserted adjust simultaneously.
    - SECS also forces pc=0.
    - A tick coinciding with an adjust is discarded; no strobes.
  - 3. tick: sc+1.
    - 59 -> sc=0, mn+1, min_pulse.
    - mn 59 -> mn=0, hr+1, hour_pulse.
    - hr 23 -> hr=0, day_pulse.
    - All carries ripple in the same edge.
- Strobes are registered and high for exactly the cycle after the causing edge, aligned with the updated state. Adjust and load never raise roll strobes.
- Adjust inputs are level-sampled. Held high for N cycles, they advance N times; debouncing and edge detection are upstream.
- Internal arithmetic is mod-N compare-and-clear, never relying on binary width overflow. Values outside the legal range are unreachable.

Test Plan:
- Reset to 00:00:00 with CLK_DIV=4, run=1 for 4*60 cycles -> SECS_OUT steps every 4th cycle; after 240 cycles MINUTES_OUT=1, SECS_OUT=0, min_pulse high exactly 1 cycle.
- Load 23:59:58 then run 8 cycles (CLK_DIV=4) -> 00:00:00; min_pulse, hour_pulse and day_pulse all high in the same cycle; AM_PM_OUT goes 1->0.
- Display decode with mode_24h=0: hr 0/11/12/13/23 -> HOURS_OUT 12/11/12/1/11 and AM_PM 0/0/1/1/1. Flip mode_24h=1 -> HOURS_OUT 0/11/12/13/23, with state untouched.
- Adjust at 10:59:30:
  - MINS pulse -> 10:00:30, no hour_pulse.
  - HOURS held 15 cycles -> 01:00:30.
  - SECS coincident with a tick -> sc=0, pc=0, no min_pulse.
- Load 24:00:00 -> load_err pulses once and time is unchanged. Load 07:30:15 with HOURS=1 the same cycle -> 07:30:15 exactly.
- Assert reset mid-count (12:34:56, pc=2), INIT_HOURS=6 -> immediately 06:00:00 with pc=0; run=0 afterwards -> time frozen for 100 cycles.

Source files
------------

// File: rtl/time_counter_prog_if.sv
// Bus bundle for the programmable h:m:s time counter: controls, adjust pulses,
// parallel load request, display outputs and rollover strobes.
interface time_counter_prog_if;
  logic       run;
  logic       mode_24h;
  logic       HOURS;
  logic       MINS;
  logic       SECS;
  logic       load_valid;
  logic [4:0] load_hours;
  logic [5:0] load_mins;
  logic [5:0] load_secs;
  logic [4:0] HOURS_OUT;
  logic [5:0] MINUTES_OUT;
  logic [5:0] SECS_OUT;
  logic       AM_PM_OUT;
  logic       min_pulse;
  logic       hour_pulse;
  logic       day_pulse;
  logic       load_err;

  modport master (
    output run, mode_24h, HOURS, MINS, SECS,
    output load_valid, load_hours, load_mins, load_secs,
    input  HOURS_OUT, MINUTES_OUT, SECS_OUT, AM_PM_OUT,
    input  min_pulse, hour_pulse, day_pulse, load_err
  );

  modport slave (
    input  run, mode_24h, HOURS, MINS, SECS,
    input  load_valid, load_hours, load_mins, load_secs,
    output HOURS_OUT, MINUTES_OUT, SECS_OUT, AM_PM_OUT,
    output min_pulse, hour_pulse, day_pulse, load_err
  );
endinterface

// File: rtl/time_counter_prog.sv
// Free-running h:m:s timekeeper with prescaled second tick, field adjust,
// validated parallel load, 12/24-hour display decode and rollover strobes.
module time_counter_prog #(
  parameter int CLK_DIV    = 1,
  parameter int INIT_HOURS = 0,
  parameter int INIT_MINS  = 0
) (
  input logic                 clk,
  input logic                 reset,
  time_counter_prog_if.slave  bus
);

  localparam int             PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] pc_q, pc_d;
  logic [4:0]    hr_q, hr_d;
  logic [5:0]    mn_q, mn_d;
  logic [5:0]    sc_q, sc_d;
  logic          minPulse_q, minPulse_d;
  logic          hourPulse_q, hourPulse_d;
  logic          dayPulse_q, dayPulse_d;
  logic          loadErr_q, loadErr_d;
  logic          tick;
  logic          loadOk;
  logic          anyAdjust;
  logic [4:0]    hoursDisp;

  assign loadOk    = (bus.load_hours <= 5'd23) && (bus.load_mins <= 6'd59) &&
                     (bus.load_secs <= 6'd59);
  assign anyAdjust = bus.HOURS | bus.MINS | bus.SECS;

  // Priority is load, then adjust, then tick; the prescaler keeps counting
  // unless a valid load or a seconds clear resets it.
  always_comb begin
    pc_d        = pc_q;
    tick        = 1'b0;
    hr_d        = hr_q;
    mn_d        = mn_q;
    sc_d        = sc_q;
    minPulse_d  = 1'b0;
    hourPulse_d = 1'b0;
    dayPulse_d  = 1'b0;
    loadErr_d   = 1'b0;

    if (bus.run) begin
      if (pc_q == PC_MAX) begin
        pc_d = '0;
        tick = 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end

    if (bus.load_valid) begin
      if (loadOk) begin
        hr_d = bus.load_hours;
        mn_d = bus.load_mins;
        sc_d = bus.load_secs;
        pc_d = '0;
      end else begin
        loadErr_d = 1'b1;
      end
    end else if (anyAdjust) begin
      if (bus.HOURS) hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
      if (bus.MINS)  mn_d = (mn_q == 6'd59) ? 6'd0 : mn_q + 6'd1;
      if (bus.SECS) begin
        sc_d = 6'd0;
        pc_d = '0;
      end
    end else if (tick) begin
      if (sc_q == 6'd59) begin
        sc_d       = 6'd0;
        minPulse_d = 1'b1;
        if (mn_q == 6'd59) begin
          mn_d        = 6'd0;
          hourPulse_d = 1'b1;
          if (hr_q == 5'd23) begin
            hr_d       = 5'd0;
            dayPulse_d = 1'b1;
          end else begin
            hr_d = hr_q + 5'd1;
          end
        end else begin
          mn_d = mn_q + 6'd1;
        end
      end else begin
        sc_d = sc_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= '0;
      hr_q        <= 5'(INIT_HOURS);
      mn_q        <= 6'(INIT_MINS);
      sc_q        <= 6'd0;
      minPulse_q  <= 1'b0;
      hourPulse_q <= 1'b0;
      dayPulse_q  <= 1'b0;
      loadErr_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      hr_q        <= hr_d;
      mn_q        <= mn_d;
      sc_q        <= sc_d;
      minPulse_q  <= minPulse_d;
      hourPulse_q <= hourPulse_d;
      dayPulse_q  <= dayPulse_d;
      loadErr_q   <= loadErr_d;
    end
  end

  // 12-hour view maps midnight/noon hours to 12 and afternoon to 1..11.
  always_comb begin
    hoursDisp = hr_q;
    if (!bus.mode_24h) begin
      if (hr_q == 5'd0)       hoursDisp = 5'd12;
      else if (hr_q > 5'd12)  hoursDisp = hr_q - 5'd12;
    end
  end

  assign bus.HOURS_OUT   = hoursDisp;
  assign bus.MINUTES_OUT = mn_q;
  assign bus.SECS_OUT    = sc_q;
  assign bus.AM_PM_OUT   = (hr_q >= 5'd12);
  assign bus.min_pulse   = minPulse_q;
  assign bus.hour_pulse  = hourPulse_q;
  assign bus.day_pulse   = dayPulse_q;
  assign bus.load_err    = loadErr_q;

endmodule
